simple_seq: RTL and testbench
=============================

// Module: simple_seq
// PURPOSE
//  Phase sequencer / fetch controller for the simple ISA core; the driving end of the PC interface.
//  Generates the 2-bit phase and signed pc_incr that the PC register consumes (PC updates only in phase 2'b11).
//  Fetches one 8-bit instruction per cycle-group from imem at the current pc and resolves branches.
//  Sits between instruction memory, the PC register and the datapath (zero flag in, instr out).
// PARAMETERS
//  FETCH_TIMEOUT  15  max cycles waiting for imem_ack before fault-halt (1..255)
// PORTS
//  clk         in   1  core clock, all logic on rising edge
//  reset       in   1  synchronous, active-high reset
//  pc          in   8  current PC from PC register; used as fetch address
//  zero_flag   in   1  datapath Z flag, sampled in EXEC
//  imem_req    out  1  fetch request, held high until imem_ack
//  imem_addr   out  8  fetch address, stable while imem_req=1
//  imem_ack    in   1  fetch complete; imem_rdata valid same cycle
//  imem_rdata  in   8  instruction byte
//  phase       out  2  00 FETCH, 01 DECODE, 10 EXEC, 11 UPDATE
//  pc_incr     out  8  signed PC increment, meaningful in UPDATE
//  instr       out  8  registered current instruction
//  halted      out  1  core stopped (HALT opcode or fetch fault)
//  fault       out  1  fetch timeout occurred (sticky until reset)
// BEHAVIOUR
//  Reset (sync, high): phase=00, imem_req=0, imem_addr=0, pc_incr=0, instr=8'h00, halted=0, fault=0, wait_cnt=0.
//  Encoding: instr[7:6] opcode; instr[5:0] signed offset off6.
//    00 NOP: incr=+1 | 01 BRZ: incr = Z ? sext(off6) : +1 | 10 JMP: incr=sext(off6) | 11 HALT.
//  FSM = phase register: FETCH -> DECODE -> EXEC -> UPDATE -> FETCH; plus terminal HALT state.
//  FETCH: imem_req=1, imem_addr=pc; stay in FETCH until imem_ack; on ack latch instr<=imem_rdata, req drops next cycle.
//    Min FETCH length 1 cycle (ack in first cycle); ack while req=0 ignored.
//    wait_cnt counts FETCH cycles without ack; reaching FETCH_TIMEOUT -> fault=1, halted=1, req=0, go HALT.
//  DECODE: 1 cycle; opcode decoded; HALT opcode -> halted=1, go HALT (phase never reaches 11, PC frozen).
//  EXEC: 1 cycle; zero_flag sampled; pc_incr registered (sext(off6) to 8 bits, two's complement).
//  UPDATE: 1 cycle, phase=11, pc_incr stable whole cycle; PC block adds it (mod 256 wrap is PC's job).
//  Throughput: 4 cycles/instr with zero-wait imem. pc_incr holds value outside UPDATE.
//  HALT: phase output held at 2'b00 with imem_req=0; exits only via reset.
//  off6=0 JMP is legal (self-loop); off6=-32 gives pc_incr=8'hE0.
//  Reset mid-fetch: req drops next cycle, late ack ignored; reset in UPDATE wins over PC update.
// STRUCTURE
//  simple_isa_pkg: phase_t enum {PH_FETCH,PH_DECODE,PH_EXEC,PH_UPDATE}, opcode_t enum,
//    OP_* constants, function sext6(logic [5:0]) -> logic signed [7:0].
//  Sub-module simple_br_resolve (comb): opcode, off6, zero_flag -> pc_incr, is_halt.
//  Top: phase/state reg, fetch handshake, wait counter, output regs.
// TESTING
//  1 Reset, zero-wait ack, NOP at 0x00 -> phases 00,01,10,11 in 4 cycles, pc_incr=8'h01 in UPDATE.
//  2 BRZ off6=6'h3C (-4), Z=1 -> pc_incr=8'hFC; same with Z=0 -> pc_incr=8'h01.
//  3 JMP off6=6'h1F -> pc_incr=8'h1F; with PC model at 0xF0, next imem_addr=0x0F (wrap).
//  4 imem_ack delayed 3 cycles -> FETCH lasts 4 cycles, imem_addr stable, req high until ack.
//  5 No ack for 15 cycles -> fault=1, halted=1, imem_req=0, phase stays 00, never 11.
//  6 HALT (8'hC0) -> halted=1 after DECODE, no further 11 phase; reset mid-FETCH -> all outputs reset values.

Source files
------------

// File: rtl/simple_isa_pkg.sv
// rtl/simple_isa_pkg.sv - shared phase/opcode types and offset sign-extension for the simple ISA core
package simple_isa_pkg;

  typedef enum logic [1:0] {
    PH_FETCH  = 2'b00,
    PH_DECODE = 2'b01,
    PH_EXEC   = 2'b10,
    PH_UPDATE = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_BRZ  = 2'b01,
    OP_JMP  = 2'b10,
    OP_HALT = 2'b11
  } opcode_t;

  localparam logic [7:0] INCR_NEXT = 8'h01;

  function automatic logic signed [7:0] sext6(input logic [5:0] off6);
    return $signed({{2{off6[5]}}, off6});
  endfunction

endpackage

// File: rtl/simple_br_resolve.sv
// rtl/simple_br_resolve.sv - combinational branch resolution: opcode, offset and Z flag to PC increment
module simple_br_resolve
  import simple_isa_pkg::*;
(
  input  logic [1:0] opcode,
  input  logic [5:0] off6,
  input  logic       zero_flag,
  output logic [7:0] pc_incr,
  output logic       is_halt
);

  always_comb begin
    pc_incr = INCR_NEXT;
    is_halt = 1'b0;
    case (opcode)
      OP_BRZ:  if (zero_flag) pc_incr = sext6(off6);
      OP_JMP:  pc_incr = sext6(off6);
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/simple_seq.sv
// rtl/simple_seq.sv - phase sequencer and fetch controller driving the PC register
module simple_seq
  import simple_isa_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  input  logic       zero_flag,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic [1:0] phase,
  output logic [7:0] pc_incr,
  output logic [7:0] instr,
  output logic       halted,
  output logic       fault
);

  localparam logic [2:0] ST_FETCH  = {1'b0, PH_FETCH};
  localparam logic [2:0] ST_DECODE = {1'b0, PH_DECODE};
  localparam logic [2:0] ST_EXEC   = {1'b0, PH_EXEC};
  localparam logic [2:0] ST_UPDATE = {1'b0, PH_UPDATE};
  localparam logic [2:0] ST_HALT   = 3'b100;

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] wait_cnt;
  logic [7:0] br_incr;
  logic       is_halt;

  simple_br_resolve u_br_resolve (
    .opcode    (instr[7:6]),
    .off6      (instr[5:0]),
    .zero_flag (zero_flag),
    .pc_incr   (br_incr),
    .is_halt   (is_halt)
  );

  // PC only moves in UPDATE, so the live pc is a stable fetch address for the whole request.
  assign imem_addr = imem_req ? pc : 8'h00;
  assign phase     = (state == ST_HALT) ? PH_FETCH : state[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      imem_req <= 1'b0;
      pc_incr  <= 8'h00;
      instr    <= 8'h00;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= 8'h00;
    end else begin
      case (state)
        ST_FETCH: begin
          // Leaving reset there is no request yet; raise it first so a stray ack is ignored.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            wait_cnt <= 8'h00;
            state    <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            fault    <= 1'b1;
            halted   <= 1'b1;
            imem_req <= 1'b0;
            state    <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc_incr <= br_incr;
          state   <= ST_UPDATE;
        end
        ST_UPDATE: begin
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        default: begin
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_seq.sv
// tb/tb_simple_seq.sv - randomized self-checking bench for simple_seq with PC register and imem models
module tb_simple_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc;
  logic       zero_flag = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic [1:0] phase;
  logic [7:0] pc_incr;
  logic [7:0] instr;
  logic       halted;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_pc;

  simple_seq #(.FETCH_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .phase      (phase),
    .pc_incr    (pc_incr),
    .instr      (instr),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // PC register: adds pc_incr only in phase 11, reset has priority
  always @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (phase == 2'b11) pc <= pc + pc_incr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_incr(input logic [7:0] ins, input logic z);
    int off;
    off = int'(ins[5:0]);
    if (off >= 32) off = off - 64;
    case (ins[7:6])
      2'd0:    return 8'h01;
      2'd1:    return z ? 8'(off) : 8'h01;
      default: return 8'(off);
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {phase, imem_req, imem_addr, pc_incr, instr, halted, fault}, 32'h0);
    reset = 1'b0;
    model_pc = 8'h00;
  endtask

  task automatic wait_req();
    int waited = 0;
    while (!imem_req && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check("req_rise", imem_req, 1);
  endtask

  task automatic run_instr(input logic [7:0] ins, input int delay, input logic z);
    logic [7:0] inc;
    int bad;
    inc = exp_incr(ins, z);
    wait_req();
    for (int d = 0; d < delay; d++) begin
      check("fetch_wait", {phase, imem_req, imem_addr}, {2'b00, 1'b1, model_pc});
      @(negedge clk);
    end
    check("fetch_addr", {phase, imem_req, imem_addr}, {2'b00, 1'b1, model_pc});
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 8'($urandom);
    check("decode", {phase, imem_req, instr}, {2'b01, 1'b0, ins});
    zero_flag = z;
    if (ins[7:6] == 2'b11) begin
      @(negedge clk);
      check("halt", {halted, fault, phase, imem_req}, {1'b1, 1'b0, 2'b00, 1'b0});
      bad = 0;
      repeat (12) begin
        @(negedge clk);
        if (phase != 2'b00 || imem_req || !halted) bad++;
      end
      check("halt_hold", bad, 0);
      return;
    end
    @(negedge clk);
    check("exec", phase, 2'b10);
    @(negedge clk);
    check("update", {phase, pc_incr}, {2'b11, inc});
    model_pc = model_pc + inc;
    @(negedge clk);
    check("next_fetch", {phase, imem_req, imem_addr, pc_incr}, {2'b00, 1'b1, model_pc, inc});
    zero_flag = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] ins;

    @(negedge clk);
    apply_reset();
    // ack before any request is raised must be ignored
    imem_ack = 1'b1;
    imem_rdata = 8'h80;
    @(negedge clk);
    check("ack_ignored", {phase, imem_req}, {2'b00, 1'b1});
    imem_ack = 1'b0;

    run_instr(8'h00, 0, 1'b0);
    run_instr(8'h7C, 0, 1'b1);
    run_instr(8'h7C, 0, 1'b0);

    apply_reset();
    run_instr(8'hB0, 0, 1'b0);
    check("pc_f0", pc, 8'hF0);
    run_instr(8'h9F, 3, 1'b0);
    check("wrap_addr", imem_addr, 8'h0F);
    run_instr(8'h80, 1, 1'b1);
    run_instr(8'hA0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ins = {2'($urandom_range(0, 2)), 6'($urandom)};
      run_instr(ins, $urandom_range(0, 5), 1'($urandom));
    end

    run_instr(8'hC0, 2, 1'b0);

    // reset mid-fetch with a late ack
    apply_reset();
    wait_req();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 8'h85;
    check("reset_mid_fetch", {phase, imem_req, imem_addr, pc_incr, instr, halted, fault}, 32'h0);
    reset = 1'b0;
    model_pc = 8'h00;
    @(negedge clk);
    check("late_ack_ignored", {phase, imem_req, instr}, {2'b00, 1'b1, 8'h00});
    imem_ack = 1'b0;
    run_instr(8'h00, 0, 1'b0);

    // reset during UPDATE wins over the PC update
    wait_req();
    imem_ack = 1'b1;
    imem_rdata = 8'h85;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_update", {phase, pc_incr}, {2'b11, 8'h05});
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_update", {phase, pc_incr, pc}, {2'b00, 8'h00, 8'h00});
    reset = 1'b0;
    model_pc = 8'h00;

    // fetch timeout
    apply_reset();
    wait_req();
    repeat (14) @(negedge clk);
    check("pre_timeout", {fault, halted, imem_req}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("timeout", {fault, halted, imem_req, phase}, {1'b1, 1'b1, 1'b0, 2'b00});
    bad = 0;
    repeat (20) begin
      imem_ack = 1'($urandom);
      @(negedge clk);
      if (phase != 2'b00 || imem_req || !fault || !halted) bad++;
    end
    imem_ack = 1'b0;
    check("timeout_hold", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
